// File: rtl/top_mixer.sv
// top_mixer: registered arithmetic/logic mixer producing a 191-bit result bus
module top_mixer (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   wire0,
    input  logic [19:0]  wire1,
    input  logic [20:0]  wire2,
    input  logic [21:0]  wire3,
    output logic [190:0] y
);
    logic signed [21:0] a22, b22;
    logic [43:0] rot;
    logic [21:0] fa, fb, fd, fe;
    logic [40:0] fc;
    logic [19:0] s1, fh;
    logic [31:0] ff;
    logic [7:0]  fg;
    logic [1:0]  fi;
    assign a22 = {{2{wire1[19]}}, wire1};
    assign b22 = {wire2[20], wire2};
    assign rot = {wire3, wire3} << wire0;
    always_ff @(posedge clk) begin
        if (rst) begin
            fa <= '0;
            fb <= '0;
            fc <= '0;
            s1 <= '0;
            fh <= '0;
            fd <= '0;
            fe <= '0;
            ff <= '0;
            fg <= '0;
            fi <= '0;
        end else begin
            fa <= a22 + b22;
            fb <= b22 - a22;
            fc <= $signed({{21{wire1[19]}}, wire1}) * $signed({{20{wire2[20]}}, wire2});
            s1 <= wire1;
            fh <= s1;
            fd <= wire3 ^ b22;
            fe <= rot[43:22];
            ff <= ff + {10'd0, wire3};
            fg <= fg + 8'd1;
            fi <= {a22 < b22, ^wire3};
        end
    end
    assign y = {fa, fb, fc, fh, fd, fe, ff, fg, fi};
endmodule

// File: tb/tb_top_mixer.sv
// tb_top_mixer: table vectors, corner sequences and randomized model comparison for top_mixer
module tb_top_mixer;
    logic         clk = 0;
    logic         rst = 1;
    logic [2:0]   wire0 = 0;
    logic [19:0]  wire1 = 0;
    logic [20:0]  wire2 = 0;
    logic [21:0]  wire3 = 0;
    logic [190:0] y;
    int tests = 0, fails = 0;

    top_mixer dut (.clk(clk), .rst(rst), .wire0(wire0), .wire1(wire1), .wire2(wire2), .wire3(wire3), .y(y));

    always #5 clk = ~clk;

    typedef struct {
        logic         r;
        logic [2:0]   w0;
        logic [19:0]  w1;
        logic [20:0]  w2;
        logic [21:0]  w3;
        logic [190:0] exp;
    } vec_t;

    logic [190:0] ey;
    longint m_acc;
    int m_cnt;
    logic [19:0] m_prev;

    task automatic check(input string name, input logic [190:0] act, input logic [190:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic [2:0] w0, input logic [19:0] w1,
                         input logic [20:0] w2, input logic [21:0] w3);
        @(negedge clk);
        rst = r; wire0 = w0; wire1 = w1; wire2 = w2; wire3 = w3;
        @(posedge clk);
        #1;
    endtask

    // Reference model: result fields from plain integer arithmetic on the sampled inputs
    task automatic model_edge(input logic r, input logic [2:0] w0, input logic [19:0] w1,
                              input logic [20:0] w2, input logic [21:0] w3);
        int a, b, par;
        longint p;
        logic [21:0] e;
        if (r) begin
            ey = '0; m_acc = 0; m_cnt = 0; m_prev = '0;
            return;
        end
        a = $signed(w1);
        b = $signed(w2);
        p = longint'(a) * longint'(b);
        par = 0;
        for (int i = 0; i < 22; i++) begin
            e[(i + w0) % 22] = w3[i];
            par ^= int'(w3[i]);
        end
        m_acc = (m_acc + longint'(w3)) & 64'hFFFF_FFFF;
        m_cnt = (m_cnt + 1) % 256;
        ey = {22'(a + b), 22'(b - a), 41'(p), m_prev, w3 ^ 22'(b), e,
              32'(m_acc), 8'(m_cnt), a < b, par[0]};
        m_prev = w1;
    endtask

    task automatic step(input logic r, input logic [2:0] w0, input logic [19:0] w1,
                        input logic [20:0] w2, input logic [21:0] w3, input string name);
        apply(r, w0, w1, w2, w3);
        model_edge(r, w0, w1, w2, w3);
        check(name, y, ey);
    endtask

    initial begin
        vec_t tbl[7];
        tbl[0] = '{1, 3'd5, 20'h12345, 21'h0ABCDE, 22'h3F00F0, 191'h0};
        tbl[1] = '{1, 3'd2, 20'hFFFFF, 21'h100000, 22'h155555, 191'h0};
        tbl[2] = '{1, 3'd7, 20'h80000, 21'h0FFFFF, 22'h2AAAAA, 191'h0};
        tbl[3] = '{0, 3'd0, 20'h00001, 21'h000002, 22'h000000,
                   {22'd3, 22'd1, 41'd2, 20'd0, 22'h000002, 22'd0, 32'd0, 8'd1, 2'b10}};
        tbl[4] = '{0, 3'd0, 20'hFFFFF, 21'h1FFFFF, 22'h000000,
                   {22'h3FFFFE, 22'd0, 41'h1, 20'd1, 22'h3FFFFF, 22'd0, 32'd0, 8'd2, 2'b00}};
        tbl[5] = '{0, 3'd3, 20'h00000, 21'h000000, 22'h200001,
                   {22'd0, 22'd0, 41'd0, 20'hFFFFF, 22'h200001, 22'h00000C, 32'h200001, 8'd3, 2'b00}};
        tbl[6] = '{0, 3'd0, 20'h00000, 21'h000000, 22'h000001,
                   {22'd0, 22'd0, 41'd0, 20'd0, 22'h000001, 22'h000001, 32'h200002, 8'd4, 2'b01}};
        for (int i = 0; i < 7; i++) begin
            apply(tbl[i].r, tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].w3);
            check($sformatf("vec%0d", i), y, tbl[i].exp);
        end

        // accumulator and counter wrap over 1025 edges of all-ones data
        apply(1, 0, 0, 0, 0);
        for (int k = 1; k <= 1025; k++) begin
            apply(0, 0, 0, 0, 22'h3FFFFF);
            if (k == 255) check("g_at_255", 191'(y[9:2]), 191'd255);
            if (k == 256) check("g_wrap_256", 191'(y[9:2]), 191'd0);
        end
        check("f_wrap_1025", 191'(y[41:10]), 191'h003FFBFF);
        check("g_at_1025", 191'(y[9:2]), 191'd1);

        // mid-run reset clears F, G and H; next edge restarts from current inputs
        apply(0, 1, 20'h00ABC, 21'h0, 22'h000010);
        apply(0, 1, 20'h00DEF, 21'h0, 22'h000010);
        apply(1, 1, 20'h00123, 21'h0, 22'h000010);
        check("midrun_rst_y", y, 191'h0);
        apply(0, 0, 20'h00456, 21'h0, 22'h0000AB);
        check("after_rst_g", 191'(y[9:2]), 191'd1);
        check("after_rst_f", 191'(y[41:10]), 191'h0000AB);
        check("after_rst_h", 191'(y[105:86]), 191'd0);
        apply(0, 0, 20'h00000, 21'h0, 22'h0);
        check("after_rst_h2", 191'(y[105:86]), 191'h00456);

        // randomized stimulus against the model, with occasional resets
        step(1, 0, 0, 0, 0, "rand_rst");
        for (int k = 0; k < 400; k++)
            step(($urandom % 25) == 0, 3'($urandom), 20'($urandom), 21'($urandom), 22'($urandom),
                 $sformatf("rand%0d", k));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
